// File: rtl/mips32_pkg.sv
// Shared definitions for the forwarding MIPS32 pipeline: opcodes, instruction
// classes, the bubble encoding and instruction-field helpers.
package mips32_pkg;

  localparam int NREGS  = 32;
  localparam int REG_AW = 5;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  // Bubble encoding: ADD R0,R0,R0, which can never change architectural state.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [2:0] {
    RR_ALU = 3'd0,
    RM_ALU = 3'd1,
    LOAD   = 3'd2,
    STORE  = 3'd3,
    BRANCH = 3'd4,
    HALT   = 3'd5
  } itype_e;

  typedef enum logic [1:0] {
    FLD_RS = 2'd0,
    FLD_RT = 2'd1,
    FLD_RD = 2'd2
  } field_e;

  function automatic logic [REG_AW-1:0] get_field(input logic [31:0] ir, input field_e f);
    case (f)
      FLD_RS:  get_field = ir[25:21];
      FLD_RT:  get_field = ir[20:16];
      FLD_RD:  get_field = ir[15:11];
      default: get_field = 5'd0;
    endcase
  endfunction

  // Unknown opcodes, and MUL when the multiplier is absent, behave as HLT.
  function automatic itype_e decode_type(input logic [5:0] op, input logic mul_en);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: decode_type = RR_ALU;
      OP_MUL:                                decode_type = mul_en ? RR_ALU : HALT;
      OP_ADDI, OP_SUBI, OP_SLTI:             decode_type = RM_ALU;
      OP_LW:                                 decode_type = LOAD;
      OP_SW:                                 decode_type = STORE;
      OP_BNEQZ, OP_BEQZ:                     decode_type = BRANCH;
      default:                               decode_type = HALT;
    endcase
  endfunction

endpackage

// File: rtl/mips32_regfile.sv
// 32 x XLEN register file with two write-through read ports and a debug port.
// R0 always reads zero and is never written.
module mips32_regfile
  import mips32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [REG_AW-1:0] i_rs_addr,
  input  logic [REG_AW-1:0] i_rt_addr,
  input  logic [REG_AW-1:0] i_dbg_addr,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [XLEN-1:0]   i_wdata,
  output logic [XLEN-1:0]   o_rs_data,
  output logic [XLEN-1:0]   o_rt_data,
  output logic [XLEN-1:0]   o_dbg_data
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_rs_byp;
  logic            w_rt_byp;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign w_rs_byp   = i_we && (i_waddr == i_rs_addr);
  assign w_rt_byp   = i_we && (i_waddr == i_rt_addr);
  assign o_rs_data  = (i_rs_addr == 5'd0) ? '0 : (w_rs_byp ? i_wdata : r_regs[i_rs_addr]);
  assign o_rt_data  = (i_rt_addr == 5'd0) ? '0 : (w_rt_byp ? i_wdata : r_regs[i_rt_addr]);
  assign o_dbg_data = (i_dbg_addr == 5'd0) ? '0 : r_regs[i_dbg_addr];

endmodule

// File: rtl/pipe_mips32_fwd.sv
// Five-stage MIPS32 pipeline with EX operand forwarding, load-use interlock,
// EX-resolved branches with a two-slot flush, and external instruction/data memories.
module pipe_mips32_fwd
  import mips32_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int IADDR_W = 10,
  parameter int DADDR_W = 10,
  parameter bit MUL_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [DADDR_W-1:0] dmem_addr,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic               dmem_we,
  output logic [XLEN-1:0]    dmem_wdata,
  output logic               halted,
  output logic [31:0]        retired,
  input  logic [4:0]         dbg_raddr,
  output logic [XLEN-1:0]    dbg_rdata
);

  logic [IADDR_W-1:0] r_pc;
  logic               r_fetch_stop;
  logic               r_halted;
  logic [31:0]        r_retired;

  logic               r_ifid_valid;
  logic [31:0]        r_ifid_ir;
  logic [IADDR_W-1:0] r_ifid_npc;

  logic               r_idex_valid;
  itype_e             r_idex_type;
  logic [5:0]         r_idex_op;
  logic [4:0]         r_idex_rs, r_idex_rt, r_idex_dest;
  logic [XLEN-1:0]    r_idex_a, r_idex_b, r_idex_imm;
  logic [IADDR_W-1:0] r_idex_npc;

  logic               r_exmem_valid;
  itype_e             r_exmem_type;
  logic [4:0]         r_exmem_dest;
  logic [XLEN-1:0]    r_exmem_alu, r_exmem_b;

  logic               r_memwb_valid;
  itype_e             r_memwb_type;
  logic [4:0]         r_memwb_dest;
  logic [XLEN-1:0]    r_memwb_alu, r_memwb_lmd;

  logic [5:0]         w_id_op;
  itype_e             w_id_type;
  logic [4:0]         w_id_rs, w_id_rt, w_id_rd, w_id_dest;
  logic [XLEN-1:0]    w_id_a, w_id_b, w_id_imm;
  logic               w_stall, w_taken, w_id_halt, w_rf_we;
  logic               w_exmem_fwd, w_memwb_fwd;
  logic [XLEN-1:0]    w_wb_res, w_fwd_a, w_fwd_b, w_op_b, w_alu;
  logic [IADDR_W-1:0] w_target;

  assign w_id_op   = r_ifid_ir[31:26];
  assign w_id_type = decode_type(w_id_op, MUL_EN);
  assign w_id_rs   = get_field(r_ifid_ir, FLD_RS);
  assign w_id_rt   = get_field(r_ifid_ir, FLD_RT);
  assign w_id_rd   = get_field(r_ifid_ir, FLD_RD);
  assign w_id_imm  = XLEN'($signed(r_ifid_ir[15:0]));
  assign w_id_dest = (w_id_type == RR_ALU) ? w_id_rd :
                     ((w_id_type == RM_ALU) || (w_id_type == LOAD)) ? w_id_rt : 5'd0;

  assign w_wb_res = (r_memwb_type == LOAD) ? r_memwb_lmd : r_memwb_alu;
  assign w_rf_we  = r_memwb_valid && !r_halted && (r_memwb_dest != 5'd0);

  mips32_regfile #(.XLEN(XLEN)) u_regfile (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rs_addr  (w_id_rs),
    .i_rt_addr  (w_id_rt),
    .i_dbg_addr (dbg_raddr),
    .i_we       (w_rf_we),
    .i_waddr    (r_memwb_dest),
    .i_wdata    (w_wb_res),
    .o_rs_data  (w_id_a),
    .o_rt_data  (w_id_b),
    .o_dbg_data (dbg_rdata)
  );

  // A load in EX cannot feed the instruction in ID yet; rt only counts for R-R ops and SW.
  assign w_stall = r_ifid_valid && r_idex_valid && (r_idex_type == LOAD) && (r_idex_dest != 5'd0) &&
                   ((r_idex_dest == w_id_rs) ||
                    (((w_id_type == RR_ALU) || (w_id_type == STORE)) && (r_idex_dest == w_id_rt)));

  // Loads sitting in EX/MEM have no data yet; the interlock guarantees nobody needs it.
  assign w_exmem_fwd = r_exmem_valid && (r_exmem_dest != 5'd0) &&
                       ((r_exmem_type == RR_ALU) || (r_exmem_type == RM_ALU));
  assign w_memwb_fwd = r_memwb_valid && (r_memwb_dest != 5'd0);

  assign w_fwd_a = (w_exmem_fwd && (r_exmem_dest == r_idex_rs)) ? r_exmem_alu :
                   (w_memwb_fwd && (r_memwb_dest == r_idex_rs)) ? w_wb_res : r_idex_a;
  assign w_fwd_b = (w_exmem_fwd && (r_exmem_dest == r_idex_rt)) ? r_exmem_alu :
                   (w_memwb_fwd && (r_memwb_dest == r_idex_rt)) ? w_wb_res : r_idex_b;
  assign w_op_b  = (r_idex_type == RR_ALU) ? w_fwd_b : r_idex_imm;

  // EX-stage ALU; LW/SW/ADDI share the adder for address and sum.
  always_comb begin
    w_alu = w_fwd_a + w_op_b;
    case (r_idex_op)
      OP_SUB, OP_SUBI: w_alu = w_fwd_a - w_op_b;
      OP_AND:          w_alu = w_fwd_a & w_op_b;
      OP_OR:           w_alu = w_fwd_a | w_op_b;
      OP_SLT, OP_SLTI: w_alu = XLEN'($signed(w_fwd_a) < $signed(w_op_b));
      OP_MUL:          w_alu = MUL_EN ? (w_fwd_a * w_op_b) : (w_fwd_a + w_op_b);
      default:         w_alu = w_fwd_a + w_op_b;
    endcase
  end

  assign w_taken   = r_idex_valid && (((r_idex_op == OP_BEQZ) && (w_fwd_a == '0)) ||
                                      ((r_idex_op == OP_BNEQZ) && (w_fwd_a != '0)));
  assign w_target  = r_idex_npc + r_idex_imm[IADDR_W-1:0];
  assign w_id_halt = r_ifid_valid && (w_id_type == HALT) && !w_taken;

  // Fetch: flush beats stall, stall beats the halt-driven fetch stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= '0;
      r_ifid_valid <= 1'b0;
      r_ifid_ir    <= NOP_INSTR;
      r_ifid_npc   <= '0;
      r_fetch_stop <= 1'b0;
    end else if (!r_halted) begin
      if (w_id_halt) r_fetch_stop <= 1'b1;
      if (w_taken) begin
        r_pc         <= w_target;
        r_ifid_valid <= 1'b0;
        r_ifid_ir    <= NOP_INSTR;
      end else if (w_stall) begin
        r_pc <= r_pc;
      end else if (r_fetch_stop || w_id_halt) begin
        r_ifid_valid <= 1'b0;
        r_ifid_ir    <= NOP_INSTR;
      end else begin
        r_pc         <= r_pc + IADDR_W'(1);
        r_ifid_valid <= 1'b1;
        r_ifid_ir    <= imem_rdata;
        r_ifid_npc   <= r_pc + IADDR_W'(1);
      end
    end
  end

  // ID/EX latch: bubble on flush or load-use stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idex_valid <= 1'b0;
      r_idex_type  <= RR_ALU;
      r_idex_op    <= OP_ADD;
      r_idex_rs    <= 5'd0;
      r_idex_rt    <= 5'd0;
      r_idex_dest  <= 5'd0;
      r_idex_a     <= '0;
      r_idex_b     <= '0;
      r_idex_imm   <= '0;
      r_idex_npc   <= '0;
    end else if (!r_halted) begin
      if (w_taken || w_stall) begin
        r_idex_valid <= 1'b0;
      end else begin
        r_idex_valid <= r_ifid_valid;
        r_idex_type  <= w_id_type;
        r_idex_op    <= w_id_op;
        r_idex_rs    <= w_id_rs;
        r_idex_rt    <= w_id_rt;
        r_idex_dest  <= w_id_dest;
        r_idex_a     <= w_id_a;
        r_idex_b     <= w_id_b;
        r_idex_imm   <= w_id_imm;
        r_idex_npc   <= r_ifid_npc;
      end
    end
  end

  // EX/MEM and MEM/WB latches plus commit bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exmem_valid <= 1'b0;
      r_exmem_type  <= RR_ALU;
      r_exmem_dest  <= 5'd0;
      r_exmem_alu   <= '0;
      r_exmem_b     <= '0;
      r_memwb_valid <= 1'b0;
      r_memwb_type  <= RR_ALU;
      r_memwb_dest  <= 5'd0;
      r_memwb_alu   <= '0;
      r_memwb_lmd   <= '0;
      r_retired     <= 32'd0;
      r_halted      <= 1'b0;
    end else if (!r_halted) begin
      r_exmem_valid <= r_idex_valid;
      r_exmem_type  <= r_idex_type;
      r_exmem_dest  <= r_idex_dest;
      r_exmem_alu   <= w_alu;
      r_exmem_b     <= w_fwd_b;
      r_memwb_valid <= r_exmem_valid;
      r_memwb_type  <= r_exmem_type;
      r_memwb_dest  <= r_exmem_dest;
      r_memwb_alu   <= r_exmem_alu;
      r_memwb_lmd   <= dmem_rdata;
      if (r_memwb_valid) begin
        r_retired <= r_retired + 32'd1;
        if (r_memwb_type == HALT) r_halted <= 1'b1;
      end
    end
  end

  assign imem_addr  = r_pc;
  assign dmem_addr  = r_exmem_alu[DADDR_W-1:0];
  assign dmem_wdata = r_exmem_b;
  assign dmem_we    = r_exmem_valid && (r_exmem_type == STORE) && !r_halted && !rst;
  assign halted     = r_halted;
  assign retired    = r_retired;

endmodule

// File: tb/tb_pipe_mips32_fwd.sv
// Directed bench: runs small programs on a MUL_EN=1 and a MUL_EN=0 core and checks
// halt timing, retire counts, register contents, stores and reset behaviour.
module tb_pipe_mips32_fwd;
  import mips32_pkg::*;

  localparam logic [31:0] HLT_W = 32'hFC00_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]  imem_addr1, imem_addr0, dmem_addr1, dmem_addr0;
  logic [31:0] imem_rdata1, imem_rdata0, dmem_rdata1, dmem_rdata0;
  logic [31:0] dmem_wdata1, dmem_wdata0, retired1, retired0, dbg_rdata1, dbg_rdata0;
  logic        dmem_we1, dmem_we0, halted1, halted0;
  logic [4:0]  dbg1 = 5'd0;
  logic [4:0]  dbg0 = 5'd0;

  logic [31:0] imem [1024];
  logic [31:0] dmem [1024];
  logic [31:0] progs [5][8];

  assign imem_rdata1 = imem[imem_addr1];
  assign imem_rdata0 = imem[imem_addr0];
  assign dmem_rdata1 = dmem[dmem_addr1];
  assign dmem_rdata0 = dmem[dmem_addr0];

  pipe_mips32_fwd #(.XLEN(32), .IADDR_W(10), .DADDR_W(10), .MUL_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
    .dmem_addr(dmem_addr1), .dmem_rdata(dmem_rdata1), .dmem_we(dmem_we1), .dmem_wdata(dmem_wdata1),
    .halted(halted1), .retired(retired1), .dbg_raddr(dbg1), .dbg_rdata(dbg_rdata1));

  pipe_mips32_fwd #(.XLEN(32), .IADDR_W(10), .DADDR_W(10), .MUL_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .imem_addr(imem_addr0), .imem_rdata(imem_rdata0),
    .dmem_addr(dmem_addr0), .dmem_rdata(dmem_rdata0), .dmem_we(dmem_we0), .dmem_wdata(dmem_wdata0),
    .halted(halted0), .retired(retired0), .dbg_raddr(dbg0), .dbg_rdata(dbg_rdata0));

  typedef struct { int halt1; int ret1; int halt0; int ret0; } pvec_t;
  typedef struct { int prog; int dut; int r; logic [31:0] val; } rvec_t;

  pvec_t pv [5];
  rvec_t rv [15];

  int n_checks = 0;
  int n_errors = 0;
  int n_stores = 0;
  logic [9:0]  st_addr;
  logic [31:0] st_data;

  function automatic logic [31:0] enc_r(input logic [5:0] op, input int rs, input int rt, input int rd);
    enc_r = {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    enc_i = {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_prog(input int p);
    for (int i = 0; i < 1024; i++) begin
      imem[i] = 32'd0;
      dmem[i] = 32'd0;
    end
    for (int i = 0; i < 8; i++) imem[i] = progs[p][i];
    dmem[100] = 32'd7;
  endtask

  task automatic rd_reg(input int d, input int r, output logic [31:0] v);
    if (d == 1) begin
      dbg1 = 5'(r); #1; v = dbg_rdata1;
    end else begin
      dbg0 = 5'(r); #1; v = dbg_rdata0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    logic [31:0] v;
    check({tag, "_pc"},      32'(imem_addr1), 32'd0);
    check({tag, "_retired"}, retired1, 32'd0);
    check({tag, "_halted"},  32'(halted1), 32'd0);
    check({tag, "_dmem_we"}, 32'(dmem_we1), 32'd0);
    rd_reg(1, 1, v);
    check({tag, "_r1"}, v, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state(tag);
    @(negedge clk); rst = 1'b0;
  endtask

  // Edge numbering starts at 1 with the first rising edge after reset release.
  task automatic run_to_halt(input int budget, output int e1, output int e0);
    e1 = -1; e0 = -1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      if (dmem_we1) begin
        n_stores++;
        st_addr = dmem_addr1;
        st_data = dmem_wdata1;
        dmem[dmem_addr1] = dmem_wdata1;
      end
      if (halted1 && e1 < 0) e1 = c;
      if (halted0 && e0 < 0) e0 = c;
      if (e1 >= 0 && e0 >= 0) break;
    end
  endtask

  initial begin
    int e1, e0, base;
    logic [31:0] v;

    for (int p = 0; p < 5; p++) for (int i = 0; i < 8; i++) progs[p][i] = 32'd0;
    // P0: straight-line dependent ALU chain
    progs[0][0] = enc_i(OP_ADDI, 0, 1, 10);
    progs[0][1] = enc_i(OP_ADDI, 1, 2, 20);
    progs[0][2] = enc_r(OP_ADD, 1, 2, 3);
    progs[0][3] = HLT_W;
    // P1: load-use then store
    progs[1][0] = enc_i(OP_ADDI, 0, 1, 100);
    progs[1][1] = enc_i(OP_LW, 1, 2, 0);
    progs[1][2] = enc_r(OP_ADD, 2, 2, 3);
    progs[1][3] = enc_i(OP_SW, 1, 3, 1);
    progs[1][4] = HLT_W;
    // P2: taken BEQZ skipping two instructions
    progs[2][0] = enc_i(OP_ADDI, 0, 1, 0);
    progs[2][1] = enc_i(OP_BEQZ, 1, 0, 2);
    progs[2][2] = enc_i(OP_ADDI, 0, 2, 1);
    progs[2][3] = enc_i(OP_ADDI, 0, 3, 1);
    progs[2][4] = enc_i(OP_ADDI, 0, 4, 5);
    progs[2][5] = HLT_W;
    // P3: backward countdown loop
    progs[3][0] = enc_i(OP_ADDI, 0, 1, 3);
    progs[3][1] = enc_i(OP_SUBI, 1, 1, 1);
    progs[3][2] = enc_i(OP_BNEQZ, 1, 0, -2);
    progs[3][3] = HLT_W;
    // P4: multiply (illegal on the MUL_EN=0 core)
    progs[4][0] = enc_i(OP_ADDI, 0, 1, 6);
    progs[4][1] = enc_i(OP_ADDI, 0, 2, 7);
    progs[4][2] = enc_r(OP_MUL, 1, 2, 3);
    progs[4][3] = HLT_W;

    pv[0] = '{halt1: 8,  ret1: 4, halt0: 8,  ret0: 4};
    pv[1] = '{halt1: 10, ret1: 5, halt0: 10, ret0: 5};
    pv[2] = '{halt1: 10, ret1: 4, halt0: 10, ret0: 4};
    pv[3] = '{halt1: 16, ret1: 8, halt0: 16, ret0: 8};
    pv[4] = '{halt1: 8,  ret1: 4, halt0: 7,  ret0: 3};

    rv[0]  = '{prog: 0, dut: 1, r: 1, val: 32'd10};
    rv[1]  = '{prog: 0, dut: 1, r: 2, val: 32'd30};
    rv[2]  = '{prog: 0, dut: 1, r: 3, val: 32'd40};
    rv[3]  = '{prog: 1, dut: 1, r: 1, val: 32'd100};
    rv[4]  = '{prog: 1, dut: 1, r: 2, val: 32'd7};
    rv[5]  = '{prog: 1, dut: 1, r: 3, val: 32'd14};
    rv[6]  = '{prog: 2, dut: 1, r: 2, val: 32'd0};
    rv[7]  = '{prog: 2, dut: 1, r: 3, val: 32'd0};
    rv[8]  = '{prog: 2, dut: 1, r: 4, val: 32'd5};
    rv[9]  = '{prog: 3, dut: 1, r: 1, val: 32'd0};
    rv[10] = '{prog: 4, dut: 1, r: 3, val: 32'd42};
    rv[11] = '{prog: 4, dut: 1, r: 2, val: 32'd7};
    rv[12] = '{prog: 4, dut: 0, r: 3, val: 32'd0};
    rv[13] = '{prog: 4, dut: 0, r: 1, val: 32'd6};
    rv[14] = '{prog: 0, dut: 0, r: 3, val: 32'd40};

    for (int p = 0; p < 5; p++) begin
      load_prog(p);
      do_reset($sformatf("p%0d_rst", p));
      base = n_stores;
      run_to_halt(60, e1, e0);
      check($sformatf("p%0d_halt_edge", p), 32'(e1), 32'(pv[p].halt1));
      check($sformatf("p%0d_retired", p), retired1, 32'(pv[p].ret1));
      check($sformatf("p%0d_halt_edge_nomul", p), 32'(e0), 32'(pv[p].halt0));
      check($sformatf("p%0d_retired_nomul", p), retired0, 32'(pv[p].ret0));
      for (int k = 0; k < 15; k++) begin
        if (rv[k].prog == p) begin
          rd_reg(rv[k].dut, rv[k].r, v);
          check($sformatf("p%0d_dut%0d_r%0d", p, rv[k].dut, rv[k].r), v, rv[k].val);
        end
      end
      if (p == 1) begin
        check("p1_store_count", 32'(n_stores - base), 32'd1);
        check("p1_store_addr", 32'(st_addr), 32'd101);
        check("p1_store_data", st_data, 32'd14);
        check("p1_mem101", dmem[101], 32'd14);
      end
    end

    // Reset in the middle of the countdown loop, then rerun to completion.
    load_prog(3);
    do_reset("loop_rst0");
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state("loop_midrst");
    @(negedge clk); rst = 1'b0;
    run_to_halt(60, e1, e0);
    check("loop_rerun_halt_edge", 32'(e1), 32'd16);
    check("loop_rerun_retired", retired1, 32'd8);
    rd_reg(1, 1, v);
    check("loop_rerun_r1", v, 32'd0);

    // Reset landing on the cycle the SW is in MEM must suppress that store.
    load_prog(1);
    do_reset("sw_rst0");
    repeat (7) @(posedge clk);
    #1;
    check("sw_in_mem_we", 32'(dmem_we1), 32'd1);
    @(negedge clk); rst = 1'b1;
    #1;
    check("sw_rst_we", 32'(dmem_we1), 32'd0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    base = n_stores;
    run_to_halt(60, e1, e0);
    check("sw_rerun_halt_edge", 32'(e1), 32'd10);
    check("sw_rerun_stores", 32'(n_stores - base), 32'd1);
    check("sw_rerun_mem101", dmem[101], 32'd14);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
